// File: rtl/pll_lock_rst_seq.sv
// Purpose : reset sequencer for the TMDS domain; qualifies the PLL lock flag and releases rst_out/ready.
// Latency : rst_out falls SYNC_STAGES+LOCK_FILTER+HOLD_CYCLES edges after lock is first sampled high;
//           it rises SYNC_STAGES edges after lock is first sampled low.
// Backpress: none; this is a free-running control block with no handshake.
//
// Ports:
//   clk           - TMDS PLL output clock; all logic is on its rising edge
//   rst           - asynchronous active-high reset
//   lock          - raw PLL lock, asynchronous to clk
//   clr_cnt       - synchronous clear of lock_loss_cnt
//   rst_out       - active-high downstream reset: asserts with rst, deasserts on a clk edge
//   ready         - high only while running; always the complement of rst_out
//   lock_lost     - one-cycle pulse on each loss of lock while running
//   lock_loss_cnt - saturating count of lock_lost pulses
//
// Build option: define PLL_LOSS_CNT_EN to include lock_loss_cnt and clr_cnt.
// Without it, lock_loss_cnt is tied to 0 and clr_cnt is ignored.
//
// Parameter limits: SYNC_STAGES >= 2, LOCK_FILTER >= 1, HOLD_CYCLES >= 1.

module pll_lock_rst_seq #(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_FILTER = 16,
    parameter int HOLD_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lock,
    input  logic       clr_cnt,
    output logic       rst_out,
    output logic       ready,
    output logic       lock_lost,
    output logic [7:0] lock_loss_cnt
);

    // One counter is shared by FILTER and HOLD.
    // It is wide enough for whichever of the two terminal counts is larger.
    localparam int CNT_MAX = (LOCK_FILTER > HOLD_CYCLES) ? LOCK_FILTER : HOLD_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] FILT_END = CNT_W'(LOCK_FILTER);
    localparam logic [CNT_W-1:0] HOLD_END = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_FILTER = 2'd1,
        ST_HOLD   = 2'd2,
        ST_RUN    = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Lock synchroniser.
    // Samples enter at bit 0, and the oldest sample is lock_s.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], lock};
        end
    end

    assign lock_s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Qualification FSM
    // ------------------------------------------------------------------
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             lost_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_WAIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        lost_nxt  = 1'b0;
        case (state)
            ST_WAIT: begin
                cnt_nxt = '0;
                if (lock_s) begin
                    // This cycle is the first qualified-high cycle, so the count starts at 1.
                    state_nxt = ST_FILTER;
                    cnt_nxt   = CNT_ONE;
                end
            end
            ST_FILTER: begin
                if (!lock_s) begin
                    state_nxt = ST_WAIT;
                    cnt_nxt   = '0;
                end else if (cnt == FILT_END) begin
                    state_nxt = ST_HOLD;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (!lock_s) begin
                    // A drop before RUN restarts qualification without a loss pulse.
                    state_nxt = ST_WAIT;
                    cnt_nxt   = '0;
                end else if (cnt == HOLD_END) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            ST_RUN: begin
                cnt_nxt = '0;
                if (!lock_s) begin
                    state_nxt = ST_WAIT;
                    lost_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_WAIT;
                cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs.
    // These registers are decoded from the next state.
    // As a result, rst_out falls on the same edge on which the FSM enters RUN.
    // They are fed only from lock_s, so there is no combinational path from lock.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_out   <= 1'b1;
            ready     <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            rst_out   <= (state_nxt != ST_RUN);
            ready     <= (state_nxt == ST_RUN);
            lock_lost <= lost_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Lock-loss counter
    // ------------------------------------------------------------------
`ifdef PLL_LOSS_CNT_EN
    logic [7:0] loss_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loss_cnt_q <= 8'd0;
        end else if (clr_cnt) begin
            // The clear wins over the old value.
            // A pulse arriving in the same cycle is still counted.
            loss_cnt_q <= {7'd0, lock_lost};
        end else if (lock_lost && (loss_cnt_q != 8'hFF)) begin
            loss_cnt_q <= loss_cnt_q + 8'd1;
        end
    end

    assign lock_loss_cnt = loss_cnt_q;
`else
    logic unused_clr_cnt;

    assign unused_clr_cnt = clr_cnt;
    assign lock_loss_cnt  = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_rst_seq.sv
// Purpose : scoreboard bench for pll_lock_rst_seq with randomized lock activity and a run-length reference model.
// Latency : the model predicts the outputs just after every clk edge and every asynchronous rst assertion.
// Backpress: none; the monitor pops one expectation per output event.

module tb_pll_lock_rst_seq;

    localparam int S  = 2;
    localparam int LF = 4;
    localparam int H  = 8;
`ifdef PLL_LOSS_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk;
    logic       rst = 1'b1;
    logic       lock = 1'b0;
    logic       clr_cnt = 1'b0;
    logic       rst_out;
    logic       ready;
    logic       lock_lost;
    logic [7:0] lock_loss_cnt;

    pll_lock_rst_seq #(
        .SYNC_STAGES(S),
        .LOCK_FILTER(LF),
        .HOLD_CYCLES(H)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .lock         (lock),
        .clr_cnt      (clr_cnt),
        .rst_out      (rst_out),
        .ready        (ready),
        .lock_lost    (lock_lost),
        .lock_loss_cnt(lock_loss_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic       rst_out;
        logic       ready;
        logic       lost;
        logic [7:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    bit   active      = 1'b0;

    // Reference model.
    // The model runs behind ready iff the most recent LF+H+1 lock samples, delayed by S edges, were all high.
    bit   samp[$];
    bit   m_ready;
    bit   m_lost;
    int   m_cnt;

    function automatic bit model_window_ok();
        int sz;
        int need;
        sz   = samp.size();
        need = LF + H + 1;
        if (sz < S + need) return 1'b0;
        for (int i = 0; i < need; i++) begin
            if (!samp[sz - 1 - S - i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        samp.delete();
        m_ready = 1'b0;
        m_lost  = 1'b0;
        m_cnt   = 0;
    endtask

    function automatic exp_t reset_exp();
        exp_t e;
        e.rst_out = 1'b1;
        e.ready   = 1'b0;
        e.lost    = 1'b0;
        e.cnt     = 8'd0;
        return e;
    endfunction

    // Drive one cycle of inputs at the falling edge.
    // Then predict the outputs that follow the next rising edge.
    task automatic step(input logic lk, input logic clr, input logic r);
        exp_t e;
        bit   nr;
        bit   nl;
        int   nc;
        @(negedge clk);
        rst     = r;
        lock    = lk;
        clr_cnt = clr;
        if (r) begin
            model_reset();
            e = reset_exp();
        end else begin
            samp.push_back(lk);
            nr = model_window_ok();
            nl = m_ready && !nr;
            if (!CNT_EN)      nc = 0;
            else if (clr)     nc = m_lost ? 1 : 0;
            else if (m_lost)  nc = (m_cnt < 255) ? m_cnt + 1 : 255;
            else              nc = m_cnt;
            m_ready = nr;
            m_lost  = nl;
            m_cnt   = nc;
            e.rst_out = !nr;
            e.ready   = nr;
            e.lost    = nl;
            e.cnt     = 8'(nc);
        end
        exp_q.push_back(e);
        active = 1'b1;
    endtask

    // Assert rst away from any clk edge.
    // Two expectations are queued:
    //   - one for the immediate response to rst;
    //   - one for the clk edge that follows while rst is still high.
    task automatic async_rst();
        @(negedge clk);
        #2;
        model_reset();
        exp_q.push_back(reset_exp());
        exp_q.push_back(reset_exp());
        rst = 1'b1;
    endtask

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s vec %0d t=%0t: got %0d want %0d", nm, vectors, $time, got, want);
        end
    endtask

    // Monitor: the outputs are presented after every clk edge and after every rst assertion.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or posedge rst);
            #1;
            if (exp_q.size() == 0) begin
                if (active) begin
                    miscompares++;
                    $display("FAIL underflow t=%0t: got no expectation want one", $time);
                end
            end else begin
                e = exp_q.pop_front();
                vectors++;
                chk("rst_out",       {7'd0, rst_out},   {7'd0, e.rst_out});
                chk("ready",         {7'd0, ready},     {7'd0, e.ready});
                chk("lock_lost",     {7'd0, lock_lost}, {7'd0, e.lost});
                chk("lock_loss_cnt", lock_loss_cnt,     e.cnt);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout t=%0t: got no finish want finish", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int guard;
        model_reset();

        // Hold in reset, then release with lock low.
        repeat (3) step(1'b0, 1'b0, 1'b1);
        repeat (50) step(1'b0, 1'b0, 1'b0);

        // First acquisition.
        repeat (20) step(1'b1, 1'b0, 1'b0);

        // Loss from RUN, then a short pulse: 3 high, 1 low, then high again.
        repeat (3) step(1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        repeat (20) step(1'b1, 1'b0, 1'b0);

        // Repeated RUN-to-loss cycles, driving the count into saturation.
        // Short high pulses are mixed in; they must not count as losses.
        for (int i = 0; i < 280; i++) begin
            repeat ($urandom_range(1, 4)) step(1'b0, 1'b0, 1'b0);
            if ($urandom_range(0, 7) == 0) begin
                repeat ($urandom_range(2, 11)) step(1'b1, 1'b0, 1'b0);
                repeat ($urandom_range(1, 3)) step(1'b0, 1'b0, 1'b0);
            end
            repeat ($urandom_range(15, 22)) step(1'b1, 1'b0, 1'b0);
        end

        // Assert clr_cnt in the same cycle as the lock_lost pulse.
        guard = 0;
        while (!m_lost && guard < 10) begin
            step(1'b0, 1'b0, 1'b0);
            guard++;
        end
        step(1'b0, 1'b1, 1'b0);
        repeat (20) step(1'b1, 1'b0, 1'b0);

        // Random activity with occasional clears.
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(1, 4)) step(1'b0, ($urandom_range(0, 3) == 0), 1'b0);
            repeat ($urandom_range(10, 22)) step(1'b1, ($urandom_range(0, 7) == 0), 1'b0);
        end

        // Asynchronous reset in the middle of HOLD.
        repeat (3) step(1'b0, 1'b0, 1'b0);
        repeat (S + LF + 3) step(1'b1, 1'b0, 1'b0);
        async_rst();
        repeat (2) step(1'b1, 1'b0, 1'b1);
        repeat (20) step(1'b1, 1'b0, 1'b0);

        // Register one loss, then assert an asynchronous reset in the middle of RUN.
        repeat (3) step(1'b0, 1'b0, 1'b0);
        repeat (20) step(1'b1, 1'b0, 1'b0);
        async_rst();
        repeat (2) step(1'b1, 1'b0, 1'b1);
        repeat (20) step(1'b1, 1'b0, 1'b0);
        repeat (5) step(1'b0, 1'b0, 1'b0);

        @(negedge clk);
        active = 1'b0;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
